i2s_adc_receiver: RTL and testbench

Deserializes the WM8731 ADC I2S stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) into parallel signed 24-bit left/right sample pairs in the system clock domain. It sits upstream of the pitch-shift datapath and mirrors the `i2s` transmitter that drives the DAC: 32-bit slots, MSB-first, one-BCK I2S delay, LRCK low = left. BCK and LRCK are treated as asynchronous inputs and oversampled by `clock`.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/i2s_adc_receiver.sv | 171 +++++++++++++++++
 tb/tb_i2s_adc_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: slot geometry, sample type and the
// receiver state encoding.
package audio_pkg;

    localparam int SAMPLE_BITS = 24;
    localparam int SLOT_BITS   = 32;

    // Bit counter width: wide enough to saturate at 63 so that overlong
    // slots still compare unequal to SLOT_BITS.
    localparam int CNT_W = 6;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic one-bit two-flop synchronizer with synchronous active-low reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops to settle an asynchronous input.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: oversamples BCK/LRCK/DAT with the system clock and
// assembles signed left/right sample pairs from 32-bit, MSB-first,
// one-BCK-delayed slots (LRCK low = left).
//
// Output handshake: data_valid is a one-cycle strobe with no ready/back-
// pressure; data_l/data_r are valid in the strobe cycle and held until the
// next strobe. frame_error is a one-cycle strobe, never coincident with
// data_valid.
module i2s_adc_receiver #(
    parameter int SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
    parameter int SLOT_BITS   = audio_pkg::SLOT_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   BCK,
    input  logic                   LRCK,
    input  logic                   DAT,
    output logic                   data_valid,
    output logic [SAMPLE_BITS-1:0] data_l,
    output logic [SAMPLE_BITS-1:0] data_r,
    output logic                   frame_error,
    output logic [1:0]             o_dbg_state
);

    import audio_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAMPLE_LIM = CNT_W'(SAMPLE_BITS);
    localparam logic [CNT_W:0]   LEN_ONE    = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   SLOT_LEN   = (CNT_W+1)'(SLOT_BITS);

    logic w_bck_s;
    logic w_lrck_s;
    logic w_dat_s;

    sync_2ff u_sync_bck  (.i_clk(clock), .i_rst_n(reset), .i_d(BCK),  .o_q(w_bck_s));
    sync_2ff u_sync_lrck (.i_clk(clock), .i_rst_n(reset), .i_d(LRCK), .o_q(w_lrck_s));
    sync_2ff u_sync_dat  (.i_clk(clock), .i_rst_n(reset), .i_d(DAT),  .o_q(w_dat_s));

    logic                   r_bck_hist;
    logic                   r_lrck_prev;
    logic [CNT_W-1:0]       r_bitcnt;
    logic [SAMPLE_BITS-1:0] r_capture;
    logic [SAMPLE_BITS-1:0] r_hold_l;
    logic [SAMPLE_BITS-1:0] r_data_l;
    logic [SAMPLE_BITS-1:0] r_data_r;
    logic                   r_data_valid;
    logic                   r_frame_error;
    state_t                 r_state;

    logic                   w_bck_rise;
    logic                   w_boundary;
    logic [CNT_W:0]         w_slot_len;
    logic                   w_len_ok;
    state_t                 w_state_next;
    logic                   w_err;
    logic                   w_hold_load;
    logic                   w_out_load;

    // BCK history flop for rising-edge detection in the clock domain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bck_hist <= 1'b0;
        end else begin
            r_bck_hist <= w_bck_s;
        end
    end

    assign w_bck_rise = w_bck_s & ~r_bck_hist;
    assign w_boundary = w_bck_rise & (w_lrck_s != r_lrck_prev);
    // The boundary bit itself is the last bit of the closing slot.
    assign w_slot_len = {1'b0, r_bitcnt} + LEN_ONE;
    assign w_len_ok   = (w_slot_len == SLOT_LEN);

    // Bit counter, LRCK tracking and MSB-first sample capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bitcnt    <= '0;
            r_lrck_prev <= 1'b0;
            r_capture   <= '0;
        end else if (w_bck_rise) begin
            if (w_boundary) begin
                r_bitcnt    <= '0;
                r_lrck_prev <= w_lrck_s;
            end else begin
                if (r_bitcnt < SAMPLE_LIM) begin
                    r_capture <= {r_capture[SAMPLE_BITS-2:0], w_dat_s};
                end
                if (r_bitcnt != '1) begin
                    r_bitcnt <= r_bitcnt + CNT_ONE;
                end
            end
        end
    end

    // Framing state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe decode; only slot boundaries move the FSM.
    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_hold_load  = 1'b0;
        w_out_load   = 1'b0;
        if (w_boundary) begin
            case (r_state)
                HUNT: begin
                    // The slot closing here is partial, so its length is not judged.
                    if (!w_lrck_s) begin
                        w_state_next = LEFT;
                    end
                end
                LEFT: begin
                    if (w_len_ok) begin
                        w_hold_load  = 1'b1;
                        w_state_next = RIGHT;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = HUNT;
                    end
                end
                RIGHT: begin
                    if (w_len_ok) begin
                        w_out_load   = 1'b1;
                        w_state_next = LEFT;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = HUNT;
                    end
                end
                default: begin
                    w_state_next = HUNT;
                end
            endcase
        end
    end

    // Left holding register, output pair and strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_hold_l      <= '0;
            r_data_l      <= '0;
            r_data_r      <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_data_valid  <= w_out_load;
            r_frame_error <= w_err;
            if (w_hold_load) begin
                r_hold_l <= r_capture;
            end
            if (w_out_load) begin
                r_data_l <= r_hold_l;
                r_data_r <= r_capture;
            end
        end
    end

    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign data_l      = r_data_l;
    assign data_r      = r_data_r;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: drives an I2S ADC stream at
// BCK = clock/4 and checks samples, framing errors and latency.
module tb_i2s_adc_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bck = 1'b1;
    logic        lrck = 1'b0;
    logic        dat = 1'b0;
    logic        data_valid;
    logic [23:0] data_l;
    logic [23:0] data_r;
    logic        frame_error;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail = 0;

    // Event monitor state, sampled on the falling clock edge.
    int   valid_cnt = 0;
    int   err_cnt = 0;
    int   wide_cnt = 0;
    int   both_cnt = 0;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;

    i2s_adc_receiver dut (
        .clock       (clk),
        .reset       (rst_n),
        .BCK         (bck),
        .LRCK        (lrck),
        .DAT         (dat),
        .data_valid  (data_valid),
        .data_l      (data_l),
        .data_r      (data_r),
        .frame_error (frame_error),
        .o_dbg_state (dbg_state)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) valid_cnt++;
        if (frame_error === 1'b1) err_cnt++;
        if ((data_valid === 1'b1 && prev_valid) || (frame_error === 1'b1 && prev_err)) wide_cnt++;
        if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
        prev_valid = (data_valid === 1'b1);
        prev_err   = (frame_error === 1'b1);
    end

    // Driver tasks. One bit per 4 clocks: data changes one cycle after the
    // previous rise, BCK falls, then rises three cycles after the data change.
    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk); lrck = lr; dat = d;
        @(negedge clk); bck = 1'b0;
        @(negedge clk);
        @(negedge clk); bck = 1'b1;
    endtask

    // Slot of len bits; the last bit already carries the next slot's LRCK.
    task automatic send_slot(input logic lr, input logic nxt, input logic [23:0] s, input int len);
        logic [31:0] w;
        w = {s, 8'hFF};
        for (int i = 0; i < len; i++) begin
            send_bit((i == len - 1) ? nxt : lr, (i < 32) ? w[31 - i] : 1'b1);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, 1'b1, l, 32);
        send_slot(1'b1, 1'b0, r, 32);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bck = 1'b1; lrck = 1'b0; dat = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_error); end
        n_checks++; if (data_l !== 24'h0) begin n_fail++; $display("FAIL reset_l: got %h want 000000", data_l); end
        n_checks++; if (data_r !== 24'h0) begin n_fail++; $display("FAIL reset_r: got %h want 000000", data_r); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_clean();
        int v0, e0;
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(24'hA5A5A5, 24'h5A5A5A);
        settle();
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL clean_preamble_valid: got %0d want 0", valid_cnt - v0); end
        send_frame(24'h123456, 24'hFEDCBA);
        settle();
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL clean_valid1: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (data_l !== 24'h123456) begin n_fail++; $display("FAIL clean_l: got %h want 123456", data_l); end
        n_checks++; if (data_r !== 24'hFEDCBA) begin n_fail++; $display("FAIL clean_r: got %h want fedcba", data_r); end
        send_frame(24'h123456, 24'hFEDCBA);
        settle();
        n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL clean_valid2: got %0d want 2", valid_cnt - v0); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL clean_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_short_left();
        int v0, e0;
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(24'h000000, 24'h000000);
        send_frame(24'h111111, 24'h222222);
        send_slot(1'b0, 1'b1, 24'h333333, 31);
        send_slot(1'b1, 1'b0, 24'h444444, 32);
        settle();
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL short_err: got %0d want 1", err_cnt - e0); end
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL short_drop_valid: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (data_l !== 24'h111111) begin n_fail++; $display("FAIL short_held_l: got %h want 111111", data_l); end
        n_checks++; if (data_r !== 24'h222222) begin n_fail++; $display("FAIL short_held_r: got %h want 222222", data_r); end
        send_frame(24'h555555, 24'h666666);
        settle();
        n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL short_recover_valid: got %0d want 2", valid_cnt - v0); end
        n_checks++; if (data_l !== 24'h555555) begin n_fail++; $display("FAIL short_recover_l: got %h want 555555", data_l); end
        n_checks++; if (data_r !== 24'h666666) begin n_fail++; $display("FAIL short_recover_r: got %h want 666666", data_r); end
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL short_err_total: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_extremes();
        int l_val, r_val;
        do_reset();
        send_frame(24'h000000, 24'h000000);
        send_frame(24'h800000, 24'h7FFFFF);
        settle();
        l_val = $signed(data_l);
        r_val = $signed(data_r);
        n_checks++; if (l_val !== -8388608) begin n_fail++; $display("FAIL extreme_l: got %0d want -8388608", l_val); end
        n_checks++; if (r_val !== 8388607) begin n_fail++; $display("FAIL extreme_r: got %0d want 8388607", r_val); end
    endtask

    task automatic test_latency();
        logic [31:0] w;
        do_reset();
        send_frame(24'h000000, 24'h000000);
        send_slot(1'b0, 1'b1, 24'h0ABCDE, 32);
        w = {24'h13579B, 8'hFF};
        for (int i = 0; i < 31; i++) send_bit(1'b1, w[31 - i]);
        // This rise carries the right slot's final bit.
        send_bit(1'b0, w[0]);
        @(negedge clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL lat_t1: got %b want 0", data_valid); end
        @(negedge clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL lat_t2: got %b want 0", data_valid); end
        @(negedge clk);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL lat_t3: got %b want 1", data_valid); end
        n_checks++; if (data_r !== 24'h13579B) begin n_fail++; $display("FAIL lat_r: got %h want 13579b", data_r); end
        @(negedge clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL lat_t4: got %b want 0", data_valid); end
    endtask

    task automatic test_reset_mid_right();
        int v0, e0;
        rst_n = 1'b0;
        v0 = valid_cnt; e0 = err_cnt;
        fork
            send_frame(24'hAAAAAA, 24'hBBBBBB);
            begin
                repeat (192) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        send_slot(1'b0, 1'b1, 24'h246802, 32);
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL midr_early_valid: got %0d want 0", valid_cnt - v0); end
        send_slot(1'b1, 1'b0, 24'h135791, 32);
        settle();
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL midr_valid: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (data_l !== 24'h246802) begin n_fail++; $display("FAIL midr_l: got %h want 246802", data_l); end
        n_checks++; if (data_r !== 24'h135791) begin n_fail++; $display("FAIL midr_r: got %h want 135791", data_r); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midr_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_reset_pulse();
        int v0, e0;
        do_reset();
        send_frame(24'h000000, 24'h000000);
        send_frame(24'h0F0F0F, 24'hF0F0F0);
        settle();
        v0 = valid_cnt; e0 = err_cnt;
        fork
            send_frame(24'hABCDEF, 24'h123123);
            begin
                repeat (40) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                n_checks++; if (data_l !== 24'h0) begin n_fail++; $display("FAIL pulse_l: got %h want 000000", data_l); end
                n_checks++; if (data_r !== 24'h0) begin n_fail++; $display("FAIL pulse_r: got %h want 000000", data_r); end
                n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_valid: got %b want 0", data_valid); end
                n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL pulse_err: got %b want 0", frame_error); end
                n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL pulse_state: got %0d want 0", dbg_state); end
                rst_n = 1'b1;
            end
        join
        settle();
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL pulse_dropped: got %0d want 0", valid_cnt - v0); end
        send_frame(24'h654321, 24'h0FEDCB);
        settle();
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL pulse_recover_valid: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (data_l !== 24'h654321) begin n_fail++; $display("FAIL pulse_recover_l: got %h want 654321", data_l); end
        n_checks++; if (data_r !== 24'h0FEDCB) begin n_fail++; $display("FAIL pulse_recover_r: got %h want 0fedcb", data_r); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL pulse_err_total: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_pulse_rules();
        n_checks++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", wide_cnt); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_short_left();
        test_extremes();
        test_latency();
        test_reset_mid_right();
        test_reset_pulse();
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
